// File: rtl/controlador_sequenciador.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter plus opcode decoder.
// Define SEQ_EARLY_END_EN to end short instructions early and return to T1.
module controlador_sequenciador (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       PC_INC,
    output logic       PC_OUT,
    output logic       JUMP,
    output logic       MAR_IN,
    output logic       RAM_OUT,
    output logic       IR_IN,
    output logic       IR_OUT,
    output logic       A_IN,
    output logic       A_OUT,
    output logic       B_IN,
    output logic       ALU_OUT,
    output logic       SUB,
    output logic       OUT_IN,
    output logic       HALT
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T5 = 6'b010000;

    logic [5:0] ring;
    logic       halted;
    logic       last_state;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_jmp;
    logic is_out;
    logic is_hlt;

    always_comb begin
        is_lda = (opcode == OP_LDA);
        is_add = (opcode == OP_ADD);
        is_sub = (opcode == OP_SUB);
        is_jmp = (opcode == OP_JMP);
        is_out = (opcode == OP_OUT);
        is_hlt = (opcode == OP_HLT);
    end

`ifdef SEQ_EARLY_END_EN
    // Last active execute state per instruction; HLT never gets past T4.
    always_comb begin
        last_state = 1'b0;
        if (is_add || is_sub || is_hlt) begin
            last_state = ring[5];
        end else if (is_lda) begin
            last_state = ring[4];
        end else begin
            last_state = ring[3];
        end
    end
`else
    always_comb begin
        last_state = ring[5];
    end
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            ring   <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            if (ring[3] && is_hlt) begin
                ring   <= T5;
                halted <= 1'b1;
            end else if (last_state) begin
                ring <= T1;
            end else begin
                ring <= {ring[4:0], ring[5]};
            end
        end
    end

    assign t_state = ring;

    always_comb begin
        PC_INC  = 1'b0;
        PC_OUT  = 1'b0;
        JUMP    = 1'b0;
        MAR_IN  = 1'b0;
        RAM_OUT = 1'b0;
        IR_IN   = 1'b0;
        IR_OUT  = 1'b0;
        A_IN    = 1'b0;
        A_OUT   = 1'b0;
        B_IN    = 1'b0;
        ALU_OUT = 1'b0;
        SUB     = 1'b0;
        OUT_IN  = 1'b0;
        HALT    = halted & ~clear;
        if (!clear && !halted) begin
            // Fetch
            if (ring[0]) begin
                PC_OUT = 1'b1;
                MAR_IN = 1'b1;
            end
            if (ring[1]) begin
                PC_INC = 1'b1;
            end
            if (ring[2]) begin
                RAM_OUT = 1'b1;
                IR_IN   = 1'b1;
            end
            // Execute
            if (ring[3]) begin
                if (is_lda || is_add || is_sub) begin
                    IR_OUT = 1'b1;
                    MAR_IN = 1'b1;
                end
                if (is_jmp) begin
                    IR_OUT = 1'b1;
                    JUMP   = 1'b1;
                end
                if (is_out) begin
                    A_OUT  = 1'b1;
                    OUT_IN = 1'b1;
                end
            end
            if (ring[4]) begin
                if (is_lda) begin
                    RAM_OUT = 1'b1;
                    A_IN    = 1'b1;
                end
                if (is_add || is_sub) begin
                    RAM_OUT = 1'b1;
                    B_IN    = 1'b1;
                    SUB     = is_sub;
                end
            end
            if (ring[5]) begin
                if (is_add || is_sub) begin
                    ALU_OUT = 1'b1;
                    A_IN    = 1'b1;
                    SUB     = is_sub;
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Scoreboard bench: microprogram-table reference model feeds a queue checked by a monitor.
module tb_controlador_sequenciador;

    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic PC_INC, PC_OUT, JUMP, MAR_IN, RAM_OUT, IR_IN, IR_OUT;
    logic A_IN, A_OUT, B_IN, ALU_OUT, SUB, OUT_IN, HALT;

    controlador_sequenciador dut (
        .clock   (clock),
        .clear   (clear),
        .opcode  (opcode),
        .t_state (t_state),
        .PC_INC  (PC_INC),
        .PC_OUT  (PC_OUT),
        .JUMP    (JUMP),
        .MAR_IN  (MAR_IN),
        .RAM_OUT (RAM_OUT),
        .IR_IN   (IR_IN),
        .IR_OUT  (IR_OUT),
        .A_IN    (A_IN),
        .A_OUT   (A_OUT),
        .B_IN    (B_IN),
        .ALU_OUT (ALU_OUT),
        .SUB     (SUB),
        .OUT_IN  (OUT_IN),
        .HALT    (HALT)
    );

    always #5 clock = ~clock;

    localparam logic [13:0] M_PC_INC  = 14'h2000;
    localparam logic [13:0] M_PC_OUT  = 14'h1000;
    localparam logic [13:0] M_JUMP    = 14'h0800;
    localparam logic [13:0] M_MAR_IN  = 14'h0400;
    localparam logic [13:0] M_RAM_OUT = 14'h0200;
    localparam logic [13:0] M_IR_IN   = 14'h0100;
    localparam logic [13:0] M_IR_OUT  = 14'h0080;
    localparam logic [13:0] M_A_IN    = 14'h0040;
    localparam logic [13:0] M_A_OUT   = 14'h0020;
    localparam logic [13:0] M_B_IN    = 14'h0010;
    localparam logic [13:0] M_ALU_OUT = 14'h0008;
    localparam logic [13:0] M_SUB     = 14'h0004;
    localparam logic [13:0] M_OUT_IN  = 14'h0002;
    localparam logic [13:0] M_HALT    = 14'h0001;
    localparam logic [13:0] M_BUS = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

    typedef struct packed {
        logic [5:0]  t;
        logic [13:0] c;
        int          cyc;
    } exp_s;

    exp_s sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model: microprogram table and instruction length per opcode.
    logic [13:0] micro[16][1:6];
    int          ilen[16];
    int          step;
    bit          halted_m;

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req,
                         input int cyc);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, req);
        end
    endtask

    task automatic init_model();
        for (int op = 0; op < 16; op++) begin
            micro[op][1] = M_PC_OUT | M_MAR_IN;
            micro[op][2] = M_PC_INC;
            micro[op][3] = M_RAM_OUT | M_IR_IN;
            micro[op][4] = '0;
            micro[op][5] = '0;
            micro[op][6] = '0;
`ifdef SEQ_EARLY_END_EN
            ilen[op] = 4;
`else
            ilen[op] = 6;
`endif
        end
        micro[0][4] = M_IR_OUT | M_MAR_IN;
        micro[0][5] = M_RAM_OUT | M_A_IN;
        micro[1][4] = M_IR_OUT | M_MAR_IN;
        micro[1][5] = M_RAM_OUT | M_B_IN;
        micro[1][6] = M_ALU_OUT | M_A_IN;
        micro[2][4] = M_IR_OUT | M_MAR_IN;
        micro[2][5] = M_RAM_OUT | M_B_IN | M_SUB;
        micro[2][6] = M_ALU_OUT | M_A_IN | M_SUB;
        micro[3][4] = M_IR_OUT | M_JUMP;
        micro[14][4] = M_A_OUT | M_OUT_IN;
`ifdef SEQ_EARLY_END_EN
        ilen[0]  = 5;
        ilen[1]  = 6;
        ilen[2]  = 6;
        ilen[15] = 6;
`endif
        step     = 1;
        halted_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic cycle(input bit clr, input logic [3:0] op);
        exp_s e;
        clear  = clr;
        opcode = op;
        e.t    = 6'(1 << (step - 1));
        if (clr)           e.c = '0;
        else if (halted_m) e.c = M_HALT;
        else               e.c = micro[op][step];
        e.cyc = cyc_no;
        sb.push_back(e);
        @(posedge clock);
        #1;
        cyc_no++;
        if (clr) begin
            step     = 1;
            halted_m = 1'b0;
        end else if (!halted_m) begin
            if (step == 4 && op == 4'hF) begin
                step     = 5;
                halted_m = 1'b1;
            end else if (step >= ilen[op]) begin
                step = 1;
            end else begin
                step = step + 1;
            end
        end
    endtask

    always @(negedge clock) begin
        exp_s e;
        logic [13:0] ctrl;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            ctrl = {PC_INC, PC_OUT, JUMP, MAR_IN, RAM_OUT, IR_IN, IR_OUT,
                    A_IN, A_OUT, B_IN, ALU_OUT, SUB, OUT_IN, HALT};
            check("t_state", {8'h00, t_state}, {8'h00, e.t}, e.cyc);
            check("ctrl", ctrl, e.c, e.cyc);
            check("bus_excl", 14'($countones(ctrl & M_BUS) > 1), 14'h0, e.cyc);
        end
    end

    initial begin
        logic [3:0] op;
        bit         clr;
        init_model();
        clear  = 1'b1;
        opcode = 4'h0;
        @(posedge clock);
        #1;
        cycle(1'b1, 4'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h3);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'hE);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h7);
        for (int i = 0; i < 24; i++) cycle(1'b0, 4'hF);
        cycle(1'b1, 4'hF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h1);
        cycle(1'b1, 4'h1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h1);
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 19) == 0);
            op  = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 3));
            cycle(clr, op);
        end
        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
